// File: rtl/mac_vert_column_sequencer_pkg.sv
// Shared types and widths for the MAC vertical column sequencer.
package mac_vert_column_sequencer_pkg;

  localparam int unsigned COL_IDX_WIDTH  = 3;
  localparam int unsigned TILE_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } seq_state_e;

  // Job configuration captured when a start is accepted
  typedef struct packed {
    logic [COL_IDX_WIDTH-1:0]  num_cols;
    logic [TILE_CNT_WIDTH-1:0] num_tiles;
  } seq_cfg_t;

endpackage

// File: rtl/mac_seq_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count compare.
module mac_seq_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term_c
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + WIDTH'(1);
  end

  assign at_term_c = (count == term);

endmodule

// File: rtl/mac_vert_column_sequencer.sv
// Sequences weight bit-columns (LSB first) into the MAC, one tile at a time.
// Optional pooling flag latch enabled by defining MAC_SEQ_POOL_EN.
module mac_vert_column_sequencer
  import mac_vert_column_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [COL_IDX_WIDTH-1:0]  cfg_num_cols,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
  input  logic                      cfg_pool,
  input  logic                      op_valid,
  output logic                      op_ready,
  output logic                      mac_en,
  output logic                      mac_load_accum,
  output logic                      mac_is_msb,
  output logic                      mac_is_pooling,
  output logic                      col_valid,
  output logic [COL_IDX_WIDTH-1:0]  mac_column_idx,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [TILE_CNT_WIDTH-1:0] res_tile_idx,
  output logic                      busy,
  output logic                      done
);

  seq_state_e                state_q, state_d;
  seq_cfg_t                  cfg_q;
  logic [COL_IDX_WIDTH-1:0]  col;
  logic [TILE_CNT_WIDTH-1:0] tile;
  logic                      col_last_c, tile_last_c;
  logic                      accept_c, in_run_c, in_result_c;
  logic                      load_pend_q;

  assign accept_c    = (state_q == ST_IDLE) & start;
  assign in_run_c    = (state_q == ST_RUN);
  assign in_result_c = (state_q == ST_RESULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cfg_q <= '0;
    else if (accept_c) cfg_q <= '{num_cols: cfg_num_cols, num_tiles: cfg_num_tiles};
  end

  // Column counter is held at 0 outside RUN so every tile restarts at the LSB
  mac_seq_counter #(.WIDTH(COL_IDX_WIDTH)) u_col_cnt (
    .clk       (clk),
    .reset     (reset),
    .en        (in_run_c & op_valid & ~col_last_c),
    .clr       (~in_run_c),
    .term      (cfg_q.num_cols),
    .count     (col),
    .at_term_c (col_last_c)
  );

  mac_seq_counter #(.WIDTH(TILE_CNT_WIDTH)) u_tile_cnt (
    .clk       (clk),
    .reset     (reset),
    .en        (in_result_c & res_ready & ~tile_last_c),
    .clr       (state_q == ST_IDLE),
    .term      (cfg_q.num_tiles),
    .count     (tile),
    .at_term_c (tile_last_c)
  );

  // Marks column 0 entering the MAC; the next enabled cycle loads the accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 load_pend_q <= 1'b0;
    else if (in_run_c & op_valid & (col == '0)) load_pend_q <= 1'b1;
    else if (mac_en)                            load_pend_q <= 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (op_valid && col_last_c) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_RESULT;
      ST_RESULT: if (res_ready) state_d = tile_last_c ? ST_IDLE : ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready       = 1'b0;
    col_valid      = 1'b0;
    mac_en         = 1'b0;
    mac_is_msb     = 1'b0;
    mac_column_idx = '0;
    res_valid      = 1'b0;
    res_tile_idx   = '0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        op_ready       = op_valid;
        col_valid      = op_valid;
        mac_en         = op_valid;
        mac_column_idx = col;
        mac_is_msb     = col_last_c;
        busy           = 1'b1;
      end
      ST_DRAIN: begin
        mac_en = 1'b1;
        busy   = 1'b1;
      end
      ST_RESULT: begin
        res_valid    = 1'b1;
        res_tile_idx = tile;
        busy         = 1'b1;
        done         = res_ready & tile_last_c;
      end
      default: ;
    endcase
    mac_load_accum = mac_en & load_pend_q;
  end

`ifdef MAC_SEQ_POOL_EN
  logic pool_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pool_q <= 1'b0;
    else if (accept_c) pool_q <= cfg_pool;
  end

  assign mac_is_pooling = (state_q != ST_IDLE) & pool_q;
`else
  logic unused_cfg_pool;
  assign unused_cfg_pool = cfg_pool;
  assign mac_is_pooling  = 1'b0;
`endif

endmodule

// File: tb/tb_mac_vert_column_sequencer.sv
// Randomized bench for mac_vert_column_sequencer with a tile/column-count reference model.
module tb_mac_vert_column_sequencer;

`ifdef MAC_SEQ_POOL_EN
  localparam bit POOL_ON = 1'b1;
`else
  localparam bit POOL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cfg_num_cols = 3'd0;
  logic [7:0] cfg_num_tiles = 8'd0;
  logic       cfg_pool = 1'b0;
  logic       op_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       op_ready, mac_en, mac_load_accum, mac_is_msb, mac_is_pooling, col_valid;
  logic [2:0] mac_column_idx;
  logic       res_valid, busy, done;
  logic [7:0] res_tile_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mac_vert_column_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_cols(cfg_num_cols), .cfg_num_tiles(cfg_num_tiles), .cfg_pool(cfg_pool),
    .op_valid(op_valid), .op_ready(op_ready),
    .mac_en(mac_en), .mac_load_accum(mac_load_accum), .mac_is_msb(mac_is_msb),
    .mac_is_pooling(mac_is_pooling), .col_valid(col_valid), .mac_column_idx(mac_column_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_tile_idx(res_tile_idx),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a job is a list of tiles; each tile consumes N+1 columns,
  // spends one drain cycle, then waits in result until accepted.
  bit m_active, m_drained, m_seen, m_pool;
  int m_n, m_t, m_tile, m_cons;

  initial m_active = 1'b0;

  always @(negedge reset) m_active = 1'b0;

  always @(posedge clk) begin
    if (!reset) m_active = 1'b0;
    else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_n = int'(cfg_num_cols); m_t = int'(cfg_num_tiles);
        m_pool = cfg_pool; m_tile = 0; m_cons = 0; m_drained = 1'b0; m_seen = 1'b0;
      end
    end else if (m_cons <= m_n) begin
      if (op_valid) begin
        if (m_cons >= 1) m_seen = 1'b1;
        m_cons++;
      end
    end else if (!m_drained) begin
      m_drained = 1'b1;
      m_seen = 1'b1;
    end else if (res_ready) begin
      if (m_tile < m_t) begin
        m_tile++; m_cons = 0; m_drained = 1'b0; m_seen = 1'b0;
      end else m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit run, drain, result, en;
    run    = m_active && (m_cons <= m_n);
    drain  = m_active && (m_cons == m_n + 1) && !m_drained;
    result = m_active && m_drained;
    en     = (run && op_valid) || drain;
    chk("busy",      int'(busy),           int'(m_active));
    chk("op_ready",  int'(op_ready),       int'(run && op_valid));
    chk("col_valid", int'(col_valid),      int'(run && op_valid));
    chk("mac_en",    int'(mac_en),         int'(en));
    chk("col_idx",   int'(mac_column_idx), run ? m_cons : 0);
    chk("is_msb",    int'(mac_is_msb),     int'(run && (m_cons == m_n)));
    chk("load_acc",  int'(mac_load_accum), int'(en && (m_cons >= 1) && !m_seen));
    chk("res_valid", int'(res_valid),      int'(result));
    chk("tile_idx",  int'(res_tile_idx),   result ? m_tile : 0);
    chk("done",      int'(done),           int'(result && res_ready && (m_tile == m_t)));
    chk("pooling",   int'(mac_is_pooling), int'(POOL_ON && m_active && m_pool));
  end

  // Leaves the caller one time unit into the first RUN cycle; cfg is then scrambled
  task automatic start_job(input int cols, input int tiles, input bit pool);
    @(posedge clk); #1;
    cfg_num_cols = 3'(cols); cfg_num_tiles = 8'(tiles); cfg_pool = pool; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_cols = 3'($urandom); cfg_num_tiles = 8'($urandom); cfg_pool = ~pool;
  endtask

  initial begin
    int dn, hs, last_tile;
    bit finished;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx",  int'(mac_column_idx), 0);
    #1 reset = 1'b1;

    // Eight columns, one tile, no stalls
    op_valid = 1'b1; res_ready = 1'b1;
    start_job(7, 0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk("t1_idx",  int'(mac_column_idx), k);
        chk("t1_msb",  int'(mac_is_msb), int'(k == 7));
        chk("t1_load", int'(mac_load_accum), int'(k == 1));
      end else if (k == 8) begin
        chk("t1_drain_en",   int'(mac_en), 1);
        chk("t1_drain_colv", int'(col_valid), 0);
      end else if (k == 9) begin
        chk("t1_res_valid", int'(res_valid), 1);
        chk("t1_done",      int'(done), 1);
      end else chk("t1_idle", int'(busy), 0);
      if (k < 10) chk("t1_pool", int'(mac_is_pooling), int'(POOL_ON));
    end

    // Single column: load lands in the drain cycle
    start_job(0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t2_msb",  int'(mac_is_msb), 1);
        chk("t2_load", int'(mac_load_accum), 0);
      end else if (k == 1) begin
        chk("t2_drain_load", int'(mac_load_accum), 1);
        chk("t2_drain_en",   int'(mac_en), 1);
      end else if (k == 2) chk("t2_res_valid", int'(res_valid), 1);
      else chk("t2_idle", int'(busy), 0);
    end

    // Three-cycle stall at column 4
    start_job(7, 0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      op_valid = !(k >= 4 && k <= 6);
      @(negedge clk);
      if (k >= 4 && k <= 6) begin
        chk("t3_stall_en",  int'(mac_en), 0);
        chk("t3_stall_idx", int'(mac_column_idx), 4);
      end
      if (k == 7)  chk("t3_resume_idx", int'(mac_column_idx), 4);
      if (k == 11) chk("t3_res_early", int'(res_valid), 0);
      if (k == 12) chk("t3_res_valid", int'(res_valid), 1);
      if (k == 13) chk("t3_idle", int'(busy), 0);
      @(posedge clk); #1;
    end

    // Three tiles, result 1 back-pressured for five cycles
    op_valid = 1'b1;
    start_job(1, 2, 1'b0);
    dn = 0;
    for (int k = 0; k < 18; k++) begin
      res_ready = !(k >= 7 && k <= 11);
      @(negedge clk);
      if (done) dn++;
      if (k == 3) chk("t4_tile0", int'(res_tile_idx), 0);
      if (k >= 7 && k <= 12) begin
        chk("t4_hold_valid", int'(res_valid), 1);
        chk("t4_hold_tile",  int'(res_tile_idx), 1);
      end
      if (k == 16) begin
        chk("t4_tile2", int'(res_tile_idx), 2);
        chk("t4_done",  int'(done), 1);
      end
      @(posedge clk); #1;
    end
    chk("t4_done_count", dn, 1);

    // Asynchronous reset in the middle of column 3, then restart straight out of reset
    res_ready = 1'b1;
    start_job(7, 5, 1'b1);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("t5_pre_idx", int'(mac_column_idx), 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_en",   int'(mac_en), 0);
    chk("t5_rst_opr",  int'(op_ready), 0);
    chk("t5_rst_idx",  int'(mac_column_idx), 0);
    chk("t5_rst_pool", int'(mac_is_pooling), 0);
    cfg_num_cols = 3'd2; cfg_num_tiles = 8'd0; start = 1'b1;
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t5_restart_busy", int'(busy), 1);
        chk("t5_restart_idx",  int'(mac_column_idx), 0);
      end
      if (k == 1) chk("t5_restart_load", int'(mac_load_accum), 1);
      if (k == 4) begin
        chk("t5_restart_res",  int'(res_valid), 1);
        chk("t5_restart_tile", int'(res_tile_idx), 0);
      end
      if (k == 5) chk("t5_restart_idle", int'(busy), 0);
    end

    // Random traffic with mid-job cfg churn and occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start         = ($urandom_range(0, 4) == 0);
      cfg_num_cols  = 3'($urandom);
      cfg_num_tiles = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
      cfg_pool      = 1'($urandom);
      op_valid      = ($urandom_range(0, 9) < 7);
      res_ready     = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
    end

    // Drain any job in flight, then run the full 256-tile job
    start = 1'b0; op_valid = 1'b1; res_ready = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk);
      if (!busy) finished = 1'b1;
    end
    chk("t6_idle_timeout", int'(finished), 1);

    start_job(0, 255, 1'b0);
    hs = 0; dn = 0; last_tile = -1; finished = 1'b0;
    for (int c = 0; c < 1000 && !finished; c++) begin
      @(negedge clk);
      if (res_valid && res_ready) hs++;
      if (done) begin dn++; last_tile = int'(res_tile_idx); end
      if (!busy) finished = 1'b1;
    end
    chk("t6_timeout",   int'(finished), 1);
    chk("t6_tiles",     hs, 256);
    chk("t6_done",      dn, 1);
    chk("t6_last_tile", last_tile, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
